yapp_rx_parser: RTL and testbench
=================================

Name: yapp_rx_parser

Overview:
- Router-side receiver for the YAPP input port. It is the DUT end of the in_data / in_data_vld / in_suspend interface.
- Accepts serial YAPP packets byte by byte: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte (XOR of header and all payload bytes).
- Buffers the bytes in a tagged FIFO and applies backpressure to the sender with in_suspend.
- Reports per-packet parity and address status to the routing logic downstream.

Parameters:
- DEPTH, 16, FIFO entries. Must be a power of 2 and ≥ 4.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  single clock; everything samples on its rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_data  in  8  packet byte from the sender
- in_data_vld  in  1  in_data is valid this cycle
- in_suspend  out  1  sender must hold the current byte and not advance
- out_data  out  8  FIFO head byte
- out_sop  out  1  head byte is a header
- out_eop  out  1  head byte is a parity byte
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  downstream pops the head this cycle
- pkt_done  out  1  one-cycle pulse when a parity byte is accepted
- pkt_addr  out  2  address of the completed packet; valid with pkt_done
- pkt_perr  out  1  parity mismatch; valid with pkt_done
- pkt_aerr  out  1  address == 3 (illegal); valid with pkt_done
- stat_pkt_cnt  out  CNT_W  completed packets, wraps
- stat_perr_cnt  out  CNT_W  packets with parity error, wraps

Behaviour:
- Reset (reset = 0): asynchronous clear.
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0, including in_suspend, out_valid and both counters.
  - A packet in flight is discarded. The first byte accepted after reset is parsed as a header.
- Accept rule: a byte is accepted on a rising edge where in_data_vld = 1 and in_suspend = 0.
  - A byte presented with in_suspend = 1 is not accepted; the sender holds it.
  - in_data_vld = 0 mid-packet is a bubble: FSM state and byte count hold.
- in_suspend is a registered flop updated with the FIFO count: in_suspend = (count ≥ DEPTH-1).
  - This guarantees the FIFO never overflows. One slot is reserved by design.
- FSM:
  - IDLE: an accepted byte is the header.
    - Latch len = data[7:2], addr = data[1:0], and seed parity = data.
    - Write {sop = 1, eop = 0, data}.
    - Go to PARITY if len = 0, else go to PAYLOAD with remaining = len.
  - PAYLOAD: each accepted byte does parity ^= data, writes {0, 0, data}, and decrements remaining.
    - Go to PARITY on the byte where remaining reaches 0.
  - PARITY: an accepted byte writes {0, 1, data} and returns to IDLE.
    - Same edge: pkt_done = 1, pkt_perr = (data != parity), pkt_aerr = (addr == 3), pkt_addr = addr.
    - stat_pkt_cnt += 1; stat_perr_cnt += pkt_perr.
    - pkt_* outputs are registered and valid in the cycle after the accepting edge. pkt_perr, pkt_aerr and pkt_addr hold until the next pkt_done.
- Packets with errors are still forwarded in full. Dropping them is the router core's job.
- FIFO:
  - First-word-fall-through; 10-bit entries {sop, eop, data}.
  - out_valid = (count ≠ 0). A pop happens when out_valid and out_ready are both 1.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Latency from an accepted byte to out_valid on an empty FIFO is 1 cycle.
- out_ready with out_valid = 0 is ignored. out_data is don't-care while out_valid = 0.
- Length range is 0..63. Packet size is len + 2 bytes, so 2..65.

Decomposition:
- yapp_pkg holds:
  - typedef yapp_state_e {IDLE, PAYLOAD, PARITY}
  - packed struct yapp_fifo_entry_t {sop, eop, data[7:0]}
  - localparams YAPP_LEN_W = 6, YAPP_ADDR_W = 2, YAPP_ILLEGAL_ADDR = 2'd3
- Sub-module yapp_rx_fifo: parameterised sync FIFO with FWFT and a count output. The parser FSM stays in yapp_rx_parser.

Test Plan:
- Good packet: send 0x0D, 0x11, 0x22, 0x33, 0x0D with out_ready = 1.
  - Out: 5 bytes in order; sop on 0x0D, eop on the final 0x0D.
  - pkt_done with pkt_addr = 1, pkt_perr = 0, pkt_aerr = 0; stat_pkt_cnt = 1.
- Zero length: send 0x02, 0x02.
  - 2 bytes out; pkt_addr = 2; no errors.
  - Then 0x07, 0xAA, 0xAD gives pkt_aerr = 1, pkt_perr = 0, and all 3 bytes are forwarded.
- Parity error: send 0x0D, 0x11, 0x22, 0x33, 0xFF.
  - pkt_perr = 1; stat_perr_cnt increments to 1; all 5 bytes are forwarded.
- Backpressure: DEPTH = 16, out_ready = 0, send a len = 20 packet (22 bytes).
  - in_suspend = 1 once count = 15; the held byte is not consumed and count never exceeds 15.
  - Set out_ready = 1: all 22 bytes arrive in order; in_suspend drops when count < 15.
- Bubbles and reset: insert in_data_vld = 0 gaps between payload bytes → same output as the gap-free case.
  - Assert reset after the 2nd payload byte → out_valid = 0, in_suspend = 0, counters = 0.
  - Next byte is treated as a header; a following good packet is parsed correctly.

Source files
------------

// File: rtl/yapp_pkg.sv
// Shared types and constants for the YAPP receive path.
//   yapp_state_e      : parser states (header, payload, parity byte)
//   yapp_fifo_entry_t : one buffered byte tagged with start/end-of-packet flags
package yapp_pkg;

    localparam int YAPP_LEN_W  = 6;
    localparam int YAPP_ADDR_W = 2;
    localparam logic [YAPP_ADDR_W-1:0] YAPP_ILLEGAL_ADDR = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } yapp_state_e;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } yapp_fifo_entry_t;

endpackage

// File: rtl/yapp_rx_parser_if.sv
// Bundle of every non-clock/reset signal of the YAPP receiver.
//   sender side   : in_data, in_data_vld -> ; <- in_suspend
//   downstream    : <- out_data/out_sop/out_eop/out_valid ; out_ready ->
//   status        : <- pkt_done/pkt_addr/pkt_perr/pkt_aerr, stat_pkt_cnt, stat_perr_cnt
// slave  = receiver (the parser), master = sender/downstream/observer.
interface yapp_rx_parser_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       in_data;
    logic             in_data_vld;
    logic             in_suspend;
    logic [7:0]       out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_valid;
    logic             out_ready;
    logic             pkt_done;
    logic [1:0]       pkt_addr;
    logic             pkt_perr;
    logic             pkt_aerr;
    logic [CNT_W-1:0] stat_pkt_cnt;
    logic [CNT_W-1:0] stat_perr_cnt;

    modport slave (
        input  in_data, in_data_vld, out_ready,
        output in_suspend, out_data, out_sop, out_eop, out_valid,
               pkt_done, pkt_addr, pkt_perr, pkt_aerr,
               stat_pkt_cnt, stat_perr_cnt
    );

    modport master (
        output in_data, in_data_vld, out_ready,
        input  in_suspend, out_data, out_sop, out_eop, out_valid,
               pkt_done, pkt_addr, pkt_perr, pkt_aerr,
               stat_pkt_cnt, stat_perr_cnt
    );
endinterface

// File: rtl/yapp_rx_parser_fifo.sv
// First-word-fall-through synchronous FIFO of tagged YAPP bytes.
//   clock, reset (async, active-low)
//   push/wr_entry : write one entry (ignored when full)
//   pop           : consume the head (ignored when empty)
//   rd_entry      : current head, meaningful while not_empty = 1
//   count         : number of stored entries, 0..DEPTH
module yapp_rx_fifo
    import yapp_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  yapp_fifo_entry_t wr_entry,
    input  logic             pop,
    output yapp_fifo_entry_t rd_entry,
    output logic [AW:0]      count,
    output logic             not_empty
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    yapp_fifo_entry_t mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_eff, pop_eff;

    always_comb begin
        push_eff = push && (count_q != FULL_LVL);
        pop_eff  = pop && (count_q != '0);
        // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
        wr_ptr_d = push_eff ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_eff  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_eff && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (!push_eff && pop_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push_eff) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_entry  = mem[rd_ptr_q];
    assign count     = count_q;
    assign not_empty = (count_q != '0);

endmodule

// File: rtl/yapp_rx_parser.sv
// YAPP input-port receiver: parses header/payload/parity bytes, buffers them
// in a tagged FWFT FIFO, throttles the sender with in_suspend and reports
// per-packet address/parity status plus wrapping statistics counters.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : yapp_rx_parser_if.slave (sender, downstream and status signals)
module yapp_rx_parser
    import yapp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic           clock,
    input logic           reset,
    yapp_rx_parser_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    // One slot is kept spare: suspend is registered, so a byte can still be
    // accepted on the edge where the FIFO reaches DEPTH-1.
    localparam logic [AW:0] SUSP_LVL = (AW+1)'(DEPTH - 1);

    yapp_state_e              state_q, state_d;
    logic [YAPP_LEN_W-1:0]    remaining_q, remaining_d;
    logic [YAPP_ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]               parity_q, parity_d;
    logic                     in_suspend_q, in_suspend_d;
    logic                     pkt_done_q, pkt_done_d;
    logic [YAPP_ADDR_W-1:0]   pkt_addr_q, pkt_addr_d;
    logic                     pkt_perr_q, pkt_perr_d;
    logic                     pkt_aerr_q, pkt_aerr_d;
    logic [CNT_W-1:0]         stat_pkt_cnt_q, stat_pkt_cnt_d;
    logic [CNT_W-1:0]         stat_perr_cnt_q, stat_perr_cnt_d;

    logic                     accept;
    logic                     push;
    logic                     pop;
    yapp_fifo_entry_t         wr_entry;
    yapp_fifo_entry_t         rd_entry;
    logic [AW:0]              fifo_count;
    logic [AW:0]              count_next;
    logic                     fifo_valid;

    yapp_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .wr_entry  (wr_entry),
        .pop       (pop),
        .rd_entry  (rd_entry),
        .count     (fifo_count),
        .not_empty (fifo_valid)
    );

    assign accept = bus.in_data_vld && !in_suspend_q;
    assign pop    = fifo_valid && bus.out_ready;

    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        addr_d          = addr_q;
        parity_d        = parity_q;
        pkt_done_d      = 1'b0;
        pkt_addr_d      = pkt_addr_q;
        pkt_perr_d      = pkt_perr_q;
        pkt_aerr_d      = pkt_aerr_q;
        stat_pkt_cnt_d  = stat_pkt_cnt_q;
        stat_perr_cnt_d = stat_perr_cnt_q;
        push            = accept;
        wr_entry.sop    = 1'b0;
        wr_entry.eop    = 1'b0;
        wr_entry.data   = bus.in_data;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    wr_entry.sop = 1'b1;
                    remaining_d  = bus.in_data[7:2];
                    addr_d       = bus.in_data[1:0];
                    parity_d     = bus.in_data;
                    state_d      = (bus.in_data[7:2] == '0) ? PARITY : PAYLOAD;
                end
                PAYLOAD: begin
                    parity_d    = parity_q ^ bus.in_data;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == YAPP_LEN_W'(1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    wr_entry.eop    = 1'b1;
                    state_d         = IDLE;
                    pkt_done_d      = 1'b1;
                    pkt_addr_d      = addr_q;
                    pkt_perr_d      = (bus.in_data != parity_q);
                    pkt_aerr_d      = (addr_q == YAPP_ILLEGAL_ADDR);
                    stat_pkt_cnt_d  = stat_pkt_cnt_q + 1'b1;
                    stat_perr_cnt_d = stat_perr_cnt_q +
                                      {{(CNT_W-1){1'b0}}, (bus.in_data != parity_q)};
                end
                default: state_d = IDLE;
            endcase
        end

        // Suspend tracks the count the FIFO will hold after this edge.
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push && pop) begin
            count_next = fifo_count - 1'b1;
        end
        in_suspend_d = (count_next >= SUSP_LVL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            addr_q          <= '0;
            parity_q        <= '0;
            in_suspend_q    <= 1'b0;
            pkt_done_q      <= 1'b0;
            pkt_addr_q      <= '0;
            pkt_perr_q      <= 1'b0;
            pkt_aerr_q      <= 1'b0;
            stat_pkt_cnt_q  <= '0;
            stat_perr_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            addr_q          <= addr_d;
            parity_q        <= parity_d;
            in_suspend_q    <= in_suspend_d;
            pkt_done_q      <= pkt_done_d;
            pkt_addr_q      <= pkt_addr_d;
            pkt_perr_q      <= pkt_perr_d;
            pkt_aerr_q      <= pkt_aerr_d;
            stat_pkt_cnt_q  <= stat_pkt_cnt_d;
            stat_perr_cnt_q <= stat_perr_cnt_d;
        end
    end

    // out_data/sop/eop are don't-care while out_valid is low; gate them
    // anyway so the outputs read as zero straight out of reset.
    assign bus.in_suspend    = in_suspend_q;
    assign bus.out_valid     = fifo_valid;
    assign bus.out_data      = fifo_valid ? rd_entry.data : 8'h00;
    assign bus.out_sop       = fifo_valid && rd_entry.sop;
    assign bus.out_eop       = fifo_valid && rd_entry.eop;
    assign bus.pkt_done      = pkt_done_q;
    assign bus.pkt_addr      = pkt_addr_q;
    assign bus.pkt_perr      = pkt_perr_q;
    assign bus.pkt_aerr      = pkt_aerr_q;
    assign bus.stat_pkt_cnt  = stat_pkt_cnt_q;
    assign bus.stat_perr_cnt = stat_perr_cnt_q;

endmodule

// File: tb/tb_yapp_rx_parser.sv
module tb_yapp_rx_parser;

    logic clock;
    logic reset;

    yapp_rx_parser_if #(.CNT_W(16)) bus ();

    yapp_rx_parser #(.DEPTH(16), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected output entries {sop, eop, data} and expected packet status
    // {addr, perr, aerr, pkt_cnt, perr_cnt}.
    logic [9:0]  exp_byte_q[$];
    logic [35:0] exp_pkt_q[$];
    logic [7:0]  tx_q[$];
    int          exp_pkt_cnt  = 0;
    int          exp_perr_cnt = 0;
    int          accepted_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from updates.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_byte: got sop=%0b eop=%0b data=0x%02h, expected none",
                             bus.out_sop, bus.out_eop, bus.out_data);
                end else begin
                    logic [9:0] e;
                    e = exp_byte_q.pop_front();
                    if ({bus.out_sop, bus.out_eop, bus.out_data} !== e) begin
                        errors++;
                        $display("FAIL out_byte: got sop=%0b eop=%0b data=0x%02h, expected sop=%0b eop=%0b data=0x%02h",
                                 bus.out_sop, bus.out_eop, bus.out_data, e[9], e[8], e[7:0]);
                    end else begin
                        $display("ok   out_byte: sop=%0b eop=%0b data=0x%02h",
                                 bus.out_sop, bus.out_eop, bus.out_data);
                    end
                end
            end
            if (bus.pkt_done) begin
                checks++;
                if (exp_pkt_q.size() == 0) begin
                    errors++;
                    $display("FAIL pkt_done: got unexpected pulse addr=%0d", bus.pkt_addr);
                end else begin
                    logic [35:0] p;
                    logic [35:0] a;
                    p = exp_pkt_q.pop_front();
                    a = {bus.pkt_addr, bus.pkt_perr, bus.pkt_aerr,
                         bus.stat_pkt_cnt, bus.stat_perr_cnt};
                    if (a !== p) begin
                        errors++;
                        $display("FAIL pkt_status: got addr=%0d perr=%0b aerr=%0b pkts=%0d perrs=%0d, expected addr=%0d perr=%0b aerr=%0b pkts=%0d perrs=%0d",
                                 a[35:34], a[33], a[32], a[31:16], a[15:0],
                                 p[35:34], p[33], p[32], p[31:16], p[15:0]);
                    end else begin
                        $display("ok   pkt_status: addr=%0d perr=%0b aerr=%0b pkts=%0d perrs=%0d",
                                 a[35:34], a[33], a[32], a[31:16], a[15:0]);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            bus.in_data_vld = 1'b0;
        end
        @(negedge clock);
        bus.in_data     = b;
        bus.in_data_vld = 1'b1;
        ok = 0;
        for (int t = 0; t < 1000; t++) begin
            if (!bus.in_suspend) begin
                @(posedge clock);
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        accepted_cnt++;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%02h never accepted", b);
        end
    endtask

    // Sends tx_q as one packet and queues the expected response.
    task automatic send_pkt(input logic [1:0] addr, input logic perr, input logic aerr,
                            input int gap);
        int n;
        n = tx_q.size();
        exp_pkt_cnt++;
        if (perr) exp_perr_cnt++;
        for (int i = 0; i < n; i++) begin
            exp_byte_q.push_back({(i == 0), (i == n - 1), tx_q[i]});
        end
        exp_pkt_q.push_back({addr, perr, aerr, 16'(exp_pkt_cnt), 16'(exp_perr_cnt)});
        for (int i = 0; i < n; i++) begin
            send_byte(tx_q[i], (i > 1 && i < n - 1) ? gap : 0);
        end
        @(negedge clock);
        bus.in_data_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_byte_q.size() != 0 || exp_pkt_q.size() != 0) && t < 300) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        check({name, "_drained"}, 32'(exp_byte_q.size() + exp_pkt_q.size()), 32'd0);
    endtask

    initial begin
        reset           = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_data_vld = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_out_valid",  32'(bus.out_valid),     32'd0);
        check("rst_in_suspend", 32'(bus.in_suspend),    32'd0);
        check("rst_pkt_done",   32'(bus.pkt_done),      32'd0);
        check("rst_pkt_cnt",    32'(bus.stat_pkt_cnt),  32'd0);
        check("rst_perr_cnt",   32'(bus.stat_perr_cnt), 32'd0);
        reset = 1'b1;
        bus.out_ready = 1'b1;

        // Good packet: len 3, addr 1, parity 0x0D.
        tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(2'd1, 1'b0, 1'b0, 0);
        drain("good");

        // Zero-length packet, then illegal address 3.
        tx_q = '{8'h02, 8'h02};
        send_pkt(2'd2, 1'b0, 1'b0, 0);
        tx_q = '{8'h07, 8'hAA, 8'hAD};
        send_pkt(2'd3, 1'b0, 1'b1, 0);
        drain("zero_len");

        // Parity error, still forwarded in full.
        tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF};
        send_pkt(2'd1, 1'b1, 1'b0, 0);
        drain("perr");
        check("perr_cnt", 32'(bus.stat_perr_cnt), 32'd1);

        // Bubbles between payload bytes: identical output.
        tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(2'd1, 1'b0, 1'b0, 3);
        drain("bubbles");

        // Backpressure: len 20, addr 1, payload 1..20, parity 0x51^0x14 = 0x45.
        tx_q = {};
        tx_q.push_back(8'h51);
        for (int i = 1; i <= 20; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'h45);
        @(negedge clock);
        bus.out_ready = 1'b0;
        accepted_cnt = 0;
        fork
            send_pkt(2'd1, 1'b0, 1'b0, 0);
            begin
                int t;
                t = 0;
                while (!bus.in_suspend && t < 100) begin
                    @(negedge clock);
                    t++;
                end
                check("bp_suspend_set", 32'(bus.in_suspend), 32'd1);
                check("bp_accepted_at_suspend", 32'(accepted_cnt), 32'd15);
                repeat (5) @(negedge clock);
                check("bp_held", 32'(accepted_cnt), 32'd15);
                check("bp_still_suspended", 32'(bus.in_suspend), 32'd1);
                bus.out_ready = 1'b1;
                @(negedge clock);
                check("bp_suspend_drop", 32'(bus.in_suspend), 32'd0);
            end
        join
        drain("backpressure");
        check("pkt_cnt_before_rst", 32'(bus.stat_pkt_cnt), 32'd6);

        // Reset mid-packet after the 2nd payload byte.
        bus.out_ready = 1'b0;
        send_byte(8'h0D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clock);
        bus.in_data_vld = 1'b0;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #2 reset = 1'b0;
        #2;
        check("mid_rst_out_valid",  32'(bus.out_valid),     32'd0);
        check("mid_rst_in_suspend", 32'(bus.in_suspend),    32'd0);
        check("mid_rst_pkt_cnt",    32'(bus.stat_pkt_cnt),  32'd0);
        check("mid_rst_perr_cnt",   32'(bus.stat_perr_cnt), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        exp_pkt_cnt  = 0;
        exp_perr_cnt = 0;
        bus.out_ready = 1'b1;

        // First byte after reset is a header again.
        tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(2'd1, 1'b0, 1'b0, 0);
        drain("post_rst");
        check("post_rst_pkt_cnt",  32'(bus.stat_pkt_cnt),  32'd1);
        check("post_rst_perr_cnt", 32'(bus.stat_perr_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
